// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-memory access unit between the EX/MEM and MEM/WB registers.
//   Turns a load/store into a req/ack transaction on a variable-latency
//   data-memory port and stalls the pipeline while it is outstanding. It also
//   does byte/half/word lane steering, sign/zero extension, alignment checks
//   and an ack timeout.
//
//   Ports
//     clk, rst                 clock (rising edge), synchronous active-low reset
//     MemRead, MemWrite        load / store present in MEM stage
//     MemSize, MemUnsigned     access size (00 b, 01 h, 1x w), zero-extend loads
//     MemAdr, MemWriteD        byte address, right-aligned store data
//     dmem_req/we/adr/be/wdata registered request to data memory
//     dmem_ack, dmem_rdata     completion strobe and read word
//     MemReadD                 registered, extended load result for MEM/WB
//     Stall                    hold upstream pipeline registers
//     AlignErr                 pulse: misaligned access dropped (combinational)
//     BusErr                   pulse in DONE: ack timeout (registered)
//
//   state  | meaning
//   IDLE   | waiting for a memory op; launches aligned ops immediately
//   ACCESS | request outstanding; waiting for ack or timeout
//   DONE   | one unstalled cycle so MEM/WB captures MemReadD

module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] MemAdr,
  input  logic [31:0] MemWriteD,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_adr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MemReadD,
  output logic        Stall,
  output logic        AlignErr,
  output logic        BusErr
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Load attributes captured at launch so extension does not depend on the
  // EX/MEM register holding still.
  logic          ld_q, ld_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lo_q, lo_d;

  logic          req_d, we_d, bus_err_d;
  logic [31:0]   adr_d, wdata_d, readd_d;
  logic [3:0]    be_d;

  logic          op, misaligned;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [31:0]   rd_shift, rd_ext;

  assign op         = MemRead | MemWrite;
  assign misaligned = ((MemSize == 2'b01) & MemAdr[0]) |
                      (MemSize[1] & (MemAdr[1:0] != 2'b00));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = MemWriteD;
    case (MemSize)
      2'b00: begin
        be_calc    = 4'b0001 << MemAdr[1:0];
        wdata_calc = {4{MemWriteD[7:0]}};
      end
      2'b01: begin
        be_calc    = MemAdr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{MemWriteD[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = MemWriteD;
      end
    endcase
  end

  // Halves are aligned, so lo_q[0] is 0 and a byte-granular shift serves both.
  always_comb begin
    rd_shift = dmem_rdata >> {lo_q, 3'b000};
    case (size_q)
      2'b00:   rd_ext = {{24{~uns_q & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   rd_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_d      = ld_q;
    size_d    = size_q;
    uns_d     = uns_q;
    lo_d      = lo_q;
    req_d     = dmem_req;
    we_d      = dmem_we;
    adr_d     = dmem_adr;
    be_d      = dmem_be;
    wdata_d   = dmem_wdata;
    readd_d   = MemReadD;
    bus_err_d = 1'b0;
    Stall     = 1'b0;
    AlignErr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (misaligned) begin
            AlignErr = 1'b1;
          end else begin
            Stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = MemWrite;
            adr_d   = {MemAdr[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            ld_d    = MemRead;
            size_d  = MemSize;
            uns_d   = MemUnsigned;
            lo_d    = MemAdr[1:0];
            // Down-counter: reaching zero marks the last allowed ACCESS cycle.
            cnt_d   = CW'(TIMEOUT - 1);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        Stall = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          if (ld_q) readd_d = rd_ext;
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          if (ld_q) readd_d = 32'hDEAD_BEEF;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ld_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lo_q       <= 2'b00;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_adr   <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      MemReadD   <= '0;
      BusErr     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_q       <= ld_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lo_q       <= lo_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_adr   <= adr_d;
      dmem_be    <= be_d;
      dmem_wdata <= wdata_d;
      MemReadD   <= readd_d;
      BusErr     <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Scoreboard bench for mem_access_unit: each launched op pushes its expected
//   request fields, stall length and result; the entry is popped and compared
//   when the unit reaches its DONE cycle.

module tb_mem_access_unit;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] MemAdr, MemWriteD;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_adr, dmem_wdata, dmem_rdata, MemReadD;
  logic [3:0]  dmem_be;
  logic        Stall, AlignErr, BusErr;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .MemAdr(MemAdr), .MemWriteD(MemWriteD),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MemReadD(MemReadD), .Stall(Stall), .AlignErr(AlignErr), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] readd;
    int          stall;
    logic        buserr;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_readd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemSize     = 2'b00;
    MemUnsigned = 1'b0;
    MemAdr      = '0;
    MemWriteD   = '0;
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] adr, input logic [31:0] rdata);
    logic [31:0] v;
    int          sel;
    sel = int'(adr[1:0]);
    case (sz)
      2'b00: begin
        v = (rdata >> (8 * sel)) & 32'h0000_00FF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (rdata >> (16 * (sel / 2))) & 32'h0000_FFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // k = ACCESS cycle (1-based) on which ack is driven; k = 0 means never ack.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] adr, input logic [31:0] wd,
                        input int k, input logic [31:0] rdata);
    exp_t e, g;
    int   cyc, a;
    logic stable;

    e.we  = wr;
    e.adr = {adr[31:2], 2'b00};
    case (sz)
      2'b00: begin e.be = 4'b0001 << adr[1:0]; e.wdata = {4{wd[7:0]}}; end
      2'b01: begin e.be = adr[1] ? 4'b1100 : 4'b0011; e.wdata = {2{wd[15:0]}}; end
      default: begin e.be = 4'b1111; e.wdata = wd; end
    endcase
    if (rd) model_readd = (k == 0) ? 32'hDEAD_BEEF : model_load(sz, uns, adr, rdata);
    e.readd  = model_readd;
    e.stall  = (k == 0) ? TIMEOUT + 1 : k + 1;
    e.buserr = (k == 0);
    sb.push_back(e);

    g.we = 1'bx; g.adr = 'x; g.be = 'x; g.wdata = 'x;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = uns;
    MemAdr = adr; MemWriteD = wd; dmem_ack = 1'b0;
    #1;
    cyc = 0; a = 0; stable = 1'b1;
    while (Stall === 1'b1 && cyc < 200) begin
      cyc++;
      if (dmem_req === 1'b1) begin
        a++;
        if (a == 1) begin
          g.we = dmem_we; g.adr = dmem_adr; g.be = dmem_be; g.wdata = dmem_wdata;
        end else if ({dmem_we, dmem_adr, dmem_be, dmem_wdata} !== {g.we, g.adr, g.be, g.wdata}) begin
          stable = 1'b0;
        end
        if (a == k) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      #1;
    end
    g.stall  = cyc;
    g.readd  = MemReadD;
    g.buserr = BusErr;
    check("done_req_low", dmem_req, 1'b0);

    e = sb.pop_front();
    check("req_we",      g.we,     e.we);
    check("req_adr",     g.adr,    e.adr);
    check("req_be",      g.be,     e.be);
    check("req_wdata",   g.wdata,  e.wdata);
    check("req_stable",  stable,   1'b1);
    check("stall_len",   g.stall,  e.stall);
    check("readd",       g.readd,  e.readd);
    check("buserr",      g.buserr, e.buserr);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    clear_inputs();
    #1;
    check("idle_stall", Stall, 1'b0);
    check("idle_req",   dmem_req, 1'b0);
  endtask

  task automatic misaligned_op(input logic rd, input logic [1:0] sz, input logic [31:0] adr);
    @(negedge clk);
    MemRead = rd; MemWrite = ~rd; MemSize = sz; MemAdr = adr; MemWriteD = 32'h5A5A_5A5A;
    #1;
    check("mis_alignerr", AlignErr, 1'b1);
    check("mis_stall",    Stall,    1'b0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("mis_pulse_end", AlignErr, 1'b0);
    check("mis_no_req",    dmem_req, 1'b0);
    check("mis_readd",     MemReadD, model_readd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    model_readd = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req",   dmem_req,   1'b0);
    check("rst_we",    dmem_we,    1'b0);
    check("rst_adr",   dmem_adr,   32'h0);
    check("rst_be",    dmem_be,    4'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_readd", MemReadD,   32'h0);
    check("rst_stall", Stall,      1'b0);
    check("rst_buserr", BusErr,    1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();

    // lw, ack on 3rd ACCESS cycle
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 3, 32'h8081_F2F3);
    idle_cycle();

    // reset while a request is outstanding, then a stray ack
    @(negedge clk);
    MemRead = 1'b1; MemSize = 2'b10; MemAdr = 32'h0000_0500;
    repeat (4) @(negedge clk);
    #1;
    check("mid_req_up", dmem_req, 1'b1);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    check("mid_rst_req",   dmem_req, 1'b0);
    check("mid_rst_stall", Stall,    1'b0);
    check("mid_rst_readd", MemReadD, 32'h0);
    model_readd = '0;
    rst = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("late_ack_req",   dmem_req, 1'b0);
    check("late_ack_readd", MemReadD, 32'h0);
    check("late_ack_stall", Stall,    1'b0);
    check("late_ack_bus",   BusErr,   1'b0);
    idle_cycle();

    // lb / lbu
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 1, 32'h0000_F200);
    idle_cycle();
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 2, 32'h0000_F200);
    idle_cycle();

    // sh upper half
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 2, 32'hFFFF_FFFF);
    idle_cycle();

    // misaligned lw and lh
    misaligned_op(1'b1, 2'b10, 32'h0000_0103);
    misaligned_op(1'b1, 2'b01, 32'h0000_0105);
    misaligned_op(1'b0, 2'b11, 32'h0000_0106);

    // ack timeout
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0);
    idle_cycle();
    check("buserr_pulse_end", BusErr, 1'b0);

    // back-to-back ops, each with its own DONE cycle
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0, 2, 32'h1122_3344);
    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0408, 32'hCAFE_F00D, 1, 32'h0);
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0406, 32'h0, 3, 32'h8000_1234);
    run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0406, 32'h0, 1, 32'h8000_1234);
    run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0403, 32'h0000_0055, 4, 32'h0);
    run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0410, 32'h0, TIMEOUT, 32'h0BAD_F00D);
    idle_cycle();
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
